pwm_fade_sequencer: RTL and testbench

Avalon-MM peripheral that ramps the duty cycle of each channel of the companion `avalon_pwm` block from its current value toward a software-written target, at a programmable rate. It sits between the CPU and the PWM peripheral, which serves as the display backlight and indicator dimming path. It issues duty-register writes to the PWM slave through its own Avalon-MM master port. Software writes only targets; this block produces the smooth fades and raises an IRQ when all channels have settled.

---
 rtl/pwm_fade_pkg.sv | 23 ++
 rtl/pwm_fade_if.sv | 43 ++++
 rtl/pwm_fade_step.sv | 37 +++
 rtl/pwm_fade_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared constants and types for the PWM fade sequencer.
// Register map, bit positions and the sequencer FSM encoding.
package pwm_fade_pkg;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_TICK   = 4'd1;
  localparam logic [3:0] A_STATUS = 4'd2;
  localparam logic [3:0] A_STEP   = 4'd3;
  localparam logic [3:0] A_TARGET = 4'd8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STATUS_DONE = 16;

  localparam logic [5:0] PWM_DUTY_BASE = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE
  } state_t;

endpackage

// File: rtl/pwm_fade_if.sv
// CPU-side register slave and PWM-side master port of the sequencer.
// The slave modport is the sequencer's view; master is the system's view.
interface pwm_fade_if;

  logic        s_chipselect;
  logic [3:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_read;
  logic [31:0] s_readdata;

  logic [5:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport slave (
    input  s_chipselect,
    input  s_address,
    input  s_write,
    input  s_writedata,
    input  s_read,
    output s_readdata,
    output m_address,
    output m_write,
    output m_writedata,
    input  m_waitrequest
  );

  modport master (
    output s_chipselect,
    output s_address,
    output s_write,
    output s_writedata,
    output s_read,
    input  s_readdata,
    input  m_address,
    input  m_write,
    input  m_writedata,
    output m_waitrequest
  );

endinterface

// File: rtl/pwm_fade_step.sv
// One ramp step from cur toward target, clamped so it never overshoots.
// Arithmetic is one bit wider than the duty value to catch carry/borrow.
module pwm_fade_step #(
  parameter int DUTY_WIDTH = 8
) (
  input  logic [DUTY_WIDTH-1:0] cur,
  input  logic [DUTY_WIDTH-1:0] target,
  input  logic [DUTY_WIDTH-1:0] step,
  output logic [DUTY_WIDTH-1:0] next
);

  localparam int W = DUTY_WIDTH + 1;

  logic [W-1:0] st;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] cur_x;
  logic [W-1:0] tgt_x;

  always_comb begin
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, target};
    st    = (step == '0) ? W'(1) : {1'b0, step};
    sum   = cur_x + st;
    diff  = cur_x - st;
    next  = cur;
    if (cur < target) begin
      next = (sum >= tgt_x) ? target : sum[DUTY_WIDTH-1:0];
    end else if (cur > target) begin
      if (cur_x < st || diff < tgt_x)
        next = target;
      else
        next = diff[DUTY_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fades each PWM duty register toward its software target at a set rate.
// Writes go out through the master port; irq flags when all have settled.
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DUTY_WIDTH = 8,
  parameter int TICK_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  pwm_fade_if.slave  bus,
  output logic       irq
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  logic                  en;
  logic                  irq_en;
  logic                  done;
  logic                  pend;
  logic [TICK_WIDTH-1:0] tick;
  logic [TICK_WIDTH-1:0] tcnt;
  logic [DUTY_WIDTH-1:0] step;
  logic [DUTY_WIDTH-1:0] target [CHANNELS];
  logic [DUTY_WIDTH-1:0] cur    [CHANNELS];
  logic [CHANNELS-1:0]   busy;
  logic [CHANNELS-1:0]   busy_q;

  state_t                state;
  state_t                state_d;
  logic [CW-1:0]         ch;
  logic [CW-1:0]         ch_d;
  logic                  take;
  logic                  accept;
  logic                  hit;
  logic [DUTY_WIDTH-1:0] nxt;

  logic                  mw_q;
  logic                  mw_d;
  logic [5:0]            ma_q;
  logic [5:0]            ma_d;
  logic [31:0]           md_q;
  logic [31:0]           md_d;

  logic                  wr;
  logic                  done_d;
  logic                  irq_en_d;
  logic [31:0]           rd;
  logic                  unused;

  assign wr     = bus.s_chipselect & bus.s_write;
  assign hit    = en && (tcnt >= tick);
  assign unused = ^bus.s_writedata;

  assign bus.m_write     = mw_q;
  assign bus.m_address   = ma_q;
  assign bus.m_writedata = md_q;
  assign bus.s_readdata  = rd;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      busy[i] = (cur[i] != target[i]);
  end

  pwm_fade_step #(
    .DUTY_WIDTH(DUTY_WIDTH)
  ) u_step (
    .cur   (cur[ch]),
    .target(target[ch]),
    .step  (step),
    .next  (nxt)
  );

  // A set event outranks a simultaneous write-1-to-clear
  always_comb begin
    done_d = done;
    if (wr && bus.s_address == A_STATUS &&
        bus.s_writedata[STATUS_DONE])
      done_d = 1'b0;
    if (|busy_q && !(|busy))
      done_d = 1'b1;
    irq_en_d = irq_en;
    if (wr && bus.s_address == A_CTRL)
      irq_en_d = bus.s_writedata[CTRL_IRQ_EN];
  end

  always_comb begin
    rd = '0;
    if (bus.s_chipselect && bus.s_read) begin
      if (bus.s_address == A_CTRL)
        rd[1:0] = {irq_en, en};
      if (bus.s_address == A_TICK)
        rd[TICK_WIDTH-1:0] = tick;
      if (bus.s_address == A_STATUS) begin
        rd[CHANNELS-1:0] = busy;
        rd[STATUS_DONE]  = done;
      end
      if (bus.s_address == A_STEP)
        rd[DUTY_WIDTH-1:0] = step;
      for (int i = 0; i < CHANNELS; i++)
        if (bus.s_address == A_TARGET + 4'(i))
          rd[DUTY_WIDTH-1:0] = target[i];
    end
  end

  always_comb begin
    state_d = state;
    ch_d    = ch;
    take    = 1'b0;
    accept  = 1'b0;
    mw_d    = mw_q;
    ma_d    = ma_q;
    md_d    = md_q;
    unique case (state)
      IDLE: begin
        if (pend) begin
          take    = 1'b1;
          ch_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (busy[ch]) begin
          mw_d    = 1'b1;
          ma_d    = PWM_DUTY_BASE + 6'(ch);
          md_d    = 32'(nxt);
          state_d = WRITE;
        end else if (ch == LAST) begin
          state_d = IDLE;
        end else begin
          ch_d = ch + 1'b1;
        end
      end
      WRITE: begin
        if (!bus.m_waitrequest) begin
          accept = 1'b1;
          mw_d   = 1'b0;
          if (ch == LAST || !en) begin
            state_d = IDLE;
          end else begin
            ch_d    = ch + 1'b1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ch    <= '0;
      mw_q  <= 1'b0;
      ma_q  <= '0;
      md_q  <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
      mw_q  <= mw_d;
      ma_q  <= ma_d;
      md_q  <= md_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
      tick   <= '0;
      step   <= DUTY_WIDTH'(1);
      done   <= 1'b0;
      irq    <= 1'b0;
      busy_q <= '0;
      tcnt   <= '0;
      pend   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        cur[i]    <= '0;
      end
    end else begin
      irq_en <= irq_en_d;
      done   <= done_d;
      irq    <= done_d & irq_en_d;
      busy_q <= busy;
      if (wr && bus.s_address == A_CTRL)
        en <= bus.s_writedata[CTRL_EN];
      if (wr && bus.s_address == A_TICK)
        tick <= bus.s_writedata[TICK_WIDTH-1:0];
      if (wr && bus.s_address == A_STEP)
        step <= bus.s_writedata[DUTY_WIDTH-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (wr && bus.s_address == A_TARGET + 4'(i))
          target[i] <= bus.s_writedata[DUTY_WIDTH-1:0];
      if (accept)
        cur[ch] <= md_q[DUTY_WIDTH-1:0];
      if (!en) begin
        tcnt <= '0;
        pend <= 1'b0;
      end else begin
        tcnt <= hit ? '0 : tcnt + 1'b1;
        pend <= hit | (pend & ~take);
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer.
// Master writes are logged at accept and compared with hand-derived values.
module tb_pwm_fade_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;

  int checks = 0;
  int errs = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t q[$];

  pwm_fade_if bus ();

  pwm_fade_sequencer #(
    .CHANNELS(4),
    .DUTY_WIDTH(8),
    .TICK_WIDTH(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && bus.m_write && !bus.m_waitrequest)
      q.push_back('{bus.m_address, bus.m_writedata, cyc});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qd(input int k);
    return (k < q.size()) ? q[k].d : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] qa(input int k);
    return (k < q.size()) ? 32'(q[k].a) : 32'hdead_beef;
  endfunction

  function automatic int qc(input int k);
    return (k < q.size()) ? q[k].c : -1000;
  endfunction

  task automatic cpu_wr(input logic [3:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    bus.s_chipselect = 1'b1;
    bus.s_write = 1'b1;
    bus.s_address = a;
    bus.s_writedata = d;
    @(negedge clk);
    bus.s_chipselect = 1'b0;
    bus.s_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    bus.s_chipselect = 1'b1;
    bus.s_read = 1'b1;
    bus.s_address = a;
    #1;
    d = bus.s_readdata;
    bus.s_chipselect = 1'b0;
    bus.s_read = 1'b0;
  endtask

  task automatic rd_check(input string tag,
                          input logic [3:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    cpu_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    int n;
    n = 0;
    do begin
      cpu_rd(4'd2, d);
      n++;
    end while ((d[3:0] != 4'h0 || bus.m_write) && n < 200);
    repeat (3) @(posedge clk);
    check(tag, {28'h0, d[3:0]}, 32'h0);
  endtask

  task automatic wait_mw(input string tag);
    int n;
    n = 0;
    while (!bus.m_write && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {31'h0, bus.m_write}, 32'h1);
  endtask

  initial begin
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        stable;

    bus.s_chipselect = 1'b0;
    bus.s_address = 4'h0;
    bus.s_write = 1'b0;
    bus.s_writedata = 32'h0;
    bus.s_read = 1'b0;
    bus.m_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    rd_check("rst_ctrl", 4'd0, 32'h0);
    rd_check("rst_tick", 4'd1, 32'h0);
    rd_check("rst_status", 4'd2, 32'h0);
    rd_check("rst_step", 4'd3, 32'h1);
    rd_check("rst_tgt0", 4'd8, 32'h0);
    rd_check("unmapped", 4'd5, 32'h0);
    check("rst_mw", {31'h0, bus.m_write}, 32'h0);
    check("rst_ma", 32'(bus.m_address), 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // up-ramp, one write every 10 clocks
    cpu_wr(4'd3, 32'h10);
    cpu_wr(4'd1, 32'd9);
    cpu_wr(4'd8, 32'h40);
    rd_check("tgt0_rb", 4'd8, 32'h40);
    q.delete();
    cpu_wr(4'd0, 32'h1);
    wait_idle("ramp_idle");
    check("ramp_n", q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ramp_d%0d", k), qd(k), 32'h10 * (k + 1));
      check($sformatf("ramp_a%0d", k), qa(k), 32'd32);
    end
    for (int k = 1; k < 4; k++)
      check($sformatf("ramp_gap%0d", k),
            32'(qc(k) - qc(k - 1)), 32'd10);
    rd_check("ramp_done", 4'd2, 32'h1_0000);
    cpu_wr(4'd2, 32'h1_0000);
    rd_check("done_w1c", 4'd2, 32'h0);

    // saturation up and down with back-to-back ticks
    cpu_wr(4'd1, 32'd0);
    cpu_wr(4'd3, 32'hF8);
    cpu_wr(4'd8, 32'hF8);
    wait_idle("sat_pre");
    cpu_wr(4'd3, 32'h10);
    q.delete();
    cpu_wr(4'd8, 32'hFF);
    wait_idle("sat_up_idle");
    check("sat_up_n", q.size(), 1);
    check("sat_up_d", qd(0), 32'hFF);
    cpu_wr(4'd3, 32'hFA);
    cpu_wr(4'd8, 32'h05);
    wait_idle("sat_mid");
    cpu_wr(4'd3, 32'h10);
    q.delete();
    cpu_wr(4'd8, 32'h00);
    wait_idle("sat_dn_idle");
    check("sat_dn_n", q.size(), 1);
    check("sat_dn_d", qd(0), 32'h00);

    // backpressure: 5 stalled cycles then accept
    bus.m_waitrequest = 1'b1;
    q.delete();
    cpu_wr(4'd8, 32'h10);
    wait_mw("bp_start");
    a0 = bus.m_address;
    d0 = bus.m_writedata;
    stable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      stable &= bus.m_write && bus.m_address == a0 &&
                bus.m_writedata == d0;
    end
    check("bp_no_acc", q.size(), 0);
    bus.m_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    check("bp_stable", {31'h0, stable}, 32'h1);
    check("bp_addr", 32'(a0), 32'd32);
    check("bp_data", d0, 32'h10);
    check("bp_mw_low", {31'h0, bus.m_write}, 32'h0);
    check("bp_acc", qd(0), 32'h10);
    wait_idle("bp_idle");

    // multi-channel: one pass writes 32 then 34
    cpu_wr(4'd0, 32'h0);
    cpu_wr(4'd2, 32'h1_0000);
    cpu_wr(4'd3, 32'h20);
    cpu_wr(4'd8, 32'h20);
    cpu_wr(4'd9, 32'h00);
    cpu_wr(4'd10, 32'h20);
    cpu_wr(4'd11, 32'h00);
    rd_check("mc_busy", 4'd2, 32'h5);
    q.delete();
    cpu_wr(4'd0, 32'h1);
    wait_idle("mc_idle");
    check("mc_n", q.size(), 2);
    check("mc_a0", qa(0), 32'd32);
    check("mc_a1", qa(1), 32'd34);
    check("mc_d0", qd(0), 32'h20);
    check("mc_d1", qd(1), 32'h20);
    check("mc_gap", 32'(qc(1) - qc(0)), 32'd3);
    rd_check("mc_done", 4'd2, 32'h1_0000);

    // disable while a write is stalled
    bus.m_waitrequest = 1'b1;
    q.delete();
    cpu_wr(4'd8, 32'h80);
    wait_mw("dis_start");
    check("dis_data", bus.m_writedata, 32'h40);
    cpu_wr(4'd0, 32'h0);
    bus.m_waitrequest = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("dis_n", q.size(), 1);
    check("dis_d", qd(0), 32'h40);
    check("dis_mw", {31'h0, bus.m_write}, 32'h0);
    rd_check("dis_busy", 4'd2, 32'h1_0001);

    // irq on completion, cleared by W1C
    cpu_wr(4'd2, 32'h1_0000);
    check("irq_pre", {31'h0, irq}, 32'h0);
    q.delete();
    cpu_wr(4'd0, 32'h3);
    wait_idle("irq_idle");
    check("irq_n", q.size(), 2);
    check("irq_last", qd(1), 32'h80);
    check("irq_set", {31'h0, irq}, 32'h1);
    cpu_wr(4'd2, 32'h1_0000);
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd_check("irq_stat", 4'd2, 32'h0);

    // asynchronous reset in the middle of a write
    bus.m_waitrequest = 1'b1;
    cpu_wr(4'd8, 32'h00);
    wait_mw("rst_mid_start");
    #1 reset_n = 1'b0;
    #1;
    check("arst_mw", {31'h0, bus.m_write}, 32'h0);
    check("arst_ma", 32'(bus.m_address), 32'h0);
    check("arst_md", bus.m_writedata, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    rd_check("arst_ctrl", 4'd0, 32'h0);
    rd_check("arst_step", 4'd3, 32'h1);
    rd_check("arst_tgt0", 4'd8, 32'h0);
    rd_check("arst_stat", 4'd2, 32'h0);
    bus.m_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
